// File: rtl/pwm_duty_sequencer_if.sv
// rtl/pwm_duty_sequencer_if.sv - request/load/duty signal bundle between host, debouncers, PWM counter and sequencer
interface pwm_duty_sequencer_if #(
    parameter int DUTY_W = 4
) ();
    logic              enable;
    logic              inc_req;
    logic              dec_req;
    logic              load_valid;
    logic [DUTY_W-1:0] load_target;
    logic              load_ready;
    logic              period_end;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] target;
    logic              duty_update;
    logic              busy;

    modport master (
        output enable, inc_req, dec_req, load_valid, load_target, period_end,
        input  load_ready, duty, target, duty_update, busy
    );

    modport slave (
        input  enable, inc_req, dec_req, load_valid, load_target, period_end,
        output load_ready, duty, target, duty_update, busy
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - arbitrates duty target requests and soft-ramps live duty at PWM period boundaries
module pwm_duty_sequencer #(
    parameter int DUTY_W    = 4,
    parameter int DUTY_MAX  = 10,
    parameter int INIT_DUTY = 5,
    parameter int STEP_DIV  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_duty_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_RAMP,
        S_STOPPING
    } state_t;

    localparam logic [DUTY_W-1:0] MAX_V    = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_V   = DUTY_W'(INIT_DUTY);
    localparam logic [7:0]        PRE_LAST = 8'(STEP_DIV - 1);

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] duty_q, duty_nxt;
    logic [DUTY_W-1:0] target_q, target_nxt;
    logic [DUTY_W-1:0] goal;
    logic [7:0]        pre_q, pre_nxt;
    logic              pend_q, pend_nxt;
    logic              upd_q;
    logic              accepting;
    logic              busy_w;
    logic              wrap;
    logic              do_step;

    assign accepting = (state == S_IDLE) || (state == S_RAMP);
    assign busy_w    = (state == S_RAMP) || (state == S_STOPPING);

    always_comb begin
        target_nxt = target_q;
        duty_nxt   = duty_q;
        pre_nxt    = 8'd0;
        pend_nxt   = pend_q;
        wrap       = 1'b0;
        do_step    = 1'b0;
        state_nxt  = state;

        // Load wins over buttons; simultaneous inc+dec cancel out.
        if (accepting) begin
            if (bus.load_valid) begin
                target_nxt = (bus.load_target > MAX_V) ? MAX_V : bus.load_target;
            end else if (bus.inc_req && !bus.dec_req) begin
                target_nxt = (target_q >= MAX_V) ? MAX_V : target_q + 1'b1;
            end else if (bus.dec_req && !bus.inc_req) begin
                target_nxt = (target_q == '0) ? '0 : target_q - 1'b1;
            end
        end

        // Goal follows the freshly accepted target so a retarget redirects the ramp at once.
        goal = (state == S_STOPPING) ? '0 : target_nxt;

        do_step = busy_w && pend_q && bus.period_end && (duty_q != goal);
        if (do_step) begin
            duty_nxt = (goal > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
        end

        if (busy_w) begin
            wrap    = (pre_q == PRE_LAST);
            pre_nxt = wrap ? 8'd0 : pre_q + 8'd1;
        end

        if (bus.enable) begin
            state_nxt = (duty_nxt == target_nxt) ? S_IDLE : S_RAMP;
        end else begin
            state_nxt = (duty_nxt == '0) ? S_OFF : S_STOPPING;
        end

        if (do_step) begin
            pend_nxt = 1'b0;
        end
        if (wrap) begin
            pend_nxt = 1'b1;
        end
        // Credit never carries over into a fresh ramp.
        if ((state_nxt == S_IDLE) || (state_nxt == S_OFF)) begin
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_OFF;
            duty_q   <= '0;
            target_q <= INIT_V;
            pre_q    <= 8'd0;
            pend_q   <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty_q   <= duty_nxt;
            target_q <= target_nxt;
            pre_q    <= pre_nxt;
            pend_q   <= pend_nxt;
            upd_q    <= do_step;
        end
    end

    assign bus.load_ready  = accepting;
    assign bus.busy        = busy_w;
    assign bus.duty        = duty_q;
    assign bus.target      = target_q;
    assign bus.duty_update = upd_q;
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - directed and randomized checks of pwm_duty_sequencer against a behavioural model
module tb_pwm_duty_sequencer;
    localparam int DUTY_W    = 4;
    localparam int DUTY_MAX  = 10;
    localparam int INIT_DUTY = 5;
    localparam int STEP_DIV  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_duty_sequencer_if #(.DUTY_W(DUTY_W)) bus ();

    pwm_duty_sequencer #(
        .DUTY_W   (DUTY_W),
        .DUTY_MAX (DUTY_MAX),
        .INIT_DUTY(INIT_DUTY),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: duty/target as integers, "on" = requests accepted, credit = one earned ramp step.
    int m_duty, m_target, m_on, m_busy, m_pre, m_credit, m_upd;
    int pcnt;
    int upd_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_duty = 0; m_target = INIT_DUTY; m_on = 0; m_busy = 0;
        m_pre = 0; m_credit = 0; m_upd = 0;
    endtask

    task automatic tick();
        int tn, goal, step, dn, wrap, pre_n, busy_n, cred_n;
        bus.period_end = (pcnt == DUTY_MAX - 1);
        tn = m_target;
        if (m_on != 0) begin
            if (bus.load_valid)
                tn = (int'(bus.load_target) > DUTY_MAX) ? DUTY_MAX : int'(bus.load_target);
            else if (bus.inc_req && !bus.dec_req)
                tn = (m_target < DUTY_MAX) ? m_target + 1 : DUTY_MAX;
            else if (bus.dec_req && !bus.inc_req)
                tn = (m_target > 0) ? m_target - 1 : 0;
        end
        goal   = (m_on != 0) ? tn : 0;
        step   = (bus.period_end && m_credit != 0 && m_busy != 0 && goal != m_duty) ? 1 : 0;
        dn     = m_duty + ((step != 0) ? ((goal > m_duty) ? 1 : -1) : 0);
        wrap   = (m_busy != 0 && m_pre == STEP_DIV - 1) ? 1 : 0;
        pre_n  = (m_busy != 0) ? (m_pre + 1) % STEP_DIV : 0;
        busy_n = bus.enable ? ((dn != tn) ? 1 : 0) : ((dn != 0) ? 1 : 0);
        cred_n = (busy_n == 0) ? 0 : (wrap != 0) ? 1 : (step != 0) ? 0 : m_credit;
        @(posedge clk);
        #1;
        m_duty = dn; m_target = tn; m_on = bus.enable ? 1 : 0; m_busy = busy_n;
        m_pre = pre_n; m_credit = cred_n; m_upd = step;
        pcnt = (pcnt + 1) % DUTY_MAX;
        check("duty", 32'(bus.duty), 32'(m_duty));
        check("target", 32'(bus.target), 32'(m_target));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("load_ready", 32'(bus.load_ready), 32'(m_on));
        check("duty_update", 32'(bus.duty_update), 32'(m_upd));
        if (bus.duty_update) upd_count++;
        bus.inc_req = 1'b0;
        bus.dec_req = 1'b0;
        bus.load_valid = 1'b0;
    endtask

    task automatic settle(input string tag, input int max_cycles);
        int n = 0;
        while (m_busy != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_settle"}, 32'(m_busy), 32'd0);
    endtask

    task automatic load(input int t);
        bus.load_valid  = 1'b1;
        bus.load_target = 4'(t);
        tick();
    endtask

    task automatic run_until_duty(input string tag, input int d, input int max_cycles);
        int n = 0;
        while (m_duty != d && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_reach"}, 32'(m_duty), 32'(d));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0; bus.inc_req = 1'b0; bus.dec_req = 1'b0;
        bus.load_valid = 1'b0; bus.load_target = '0; bus.period_end = 1'b0;
        model_reset();
        pcnt = 0; upd_count = 0;
        @(posedge clk); #1;
        check("rst_duty", 32'(bus.duty), 32'd0);
        check("rst_target", 32'(bus.target), 32'(INIT_DUTY));
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_duty_update", 32'(bus.duty_update), 32'd0);

        // Power-up ramp 0 -> INIT_DUTY, one step per period.
        rst = 1'b0;
        bus.enable = 1'b1;
        tick();
        check("pwrup_busy", 32'(bus.busy), 32'd1);
        repeat (59) tick();
        check("pwrup_duty", 32'(bus.duty), 32'd5);
        check("pwrup_updates", 32'(upd_count), 32'd5);
        check("pwrup_idle", 32'(bus.busy), 32'd0);

        // Saturation at both ends.
        load(10);
        settle("sat_hi", 300);
        repeat (3) begin bus.inc_req = 1'b1; tick(); tick(); end
        check("sat_hi_target", 32'(bus.target), 32'd10);
        check("sat_hi_duty", 32'(bus.duty), 32'd10);
        load(0);
        settle("sat_lo", 400);
        bus.dec_req = 1'b1; tick();
        check("sat_lo_target", 32'(bus.target), 32'd0);

        // Arbitration.
        bus.load_valid = 1'b1; bus.load_target = 4'd2; bus.inc_req = 1'b1; tick();
        check("arb_load_wins", 32'(bus.target), 32'd2);
        bus.inc_req = 1'b1; bus.dec_req = 1'b1; tick();
        check("arb_both_drop", 32'(bus.target), 32'd2);
        load(15);
        check("arb_clamp", 32'(bus.target), 32'd10);

        // Soft stop with ignored buttons, then resume.
        load(7);
        settle("stop_pre", 400);
        check("stop_pre_duty", 32'(bus.duty), 32'd7);
        bus.enable = 1'b0;
        tick();
        check("stop_load_ready", 32'(bus.load_ready), 32'd0);
        for (int i = 0; i < 400 && m_busy != 0; i++) begin
            if (i % 7 == 0) bus.inc_req = 1'b1;
            tick();
        end
        check("stop_duty", 32'(bus.duty), 32'd0);
        check("stop_target_kept", 32'(bus.target), 32'd7);
        bus.enable = 1'b1;
        tick();
        settle("resume", 400);
        check("resume_duty", 32'(bus.duty), 32'd7);

        // Mid-ramp retarget.
        load(2);
        settle("rt_pre", 400);
        load(8);
        run_until_duty("rt", 5, 400);
        load(4);
        settle("rt_post", 400);
        check("rt_duty", 32'(bus.duty), 32'd4);

        // Asynchronous reset mid-ramp.
        load(9);
        run_until_duty("ar", 6, 400);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("ar_duty", 32'(bus.duty), 32'd0);
        check("ar_target", 32'(bus.target), 32'(INIT_DUTY));
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_load_ready", 32'(bus.load_ready), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("ar_restart_busy", 32'(bus.busy), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) bus.enable = ~bus.enable;
            bus.inc_req = ($urandom_range(0, 7) == 0);
            bus.dec_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.load_valid  = 1'b1;
                bus.load_target = 4'($urandom_range(0, 15));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
